// File: rtl/vga_rx_decoder.sv
// VGA receive-side timing recovery: locks to sync timing, recovers x/y/de/pixel and flags timing faults.
// Optional frame checksum enabled by defining VGA_RX_FRAME_SUM_EN.
module vga_rx_decoder #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pix_en,
  input  logic        HS,
  input  logic        VS,
  input  logic [7:0]  RGB,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        de,
  output logic [7:0]  pixel_out,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err,
  output logic [15:0] frame_sum
);

  localparam logic [10:0] H_TOTAL = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] V_TOTAL = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0]  HS_LEN  = 10'(H_SYNC);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam int          GW      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t        state;
  logic          hs_prev;
  logic          vs_prev;
  logic          vs_pend;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [9:0]    hs_width;
  logic [GW-1:0] good_cnt;

  logic hs_act;
  logic vs_act;
  logic hle;
  logic vle;
  logic frame_hle;
  logic line_ok;
  logic frame_ok;
  logic chk_fail;
  logic visible;
  logic vis_de;

  // Event decode for the current sample, evaluated on pre-update counters.
  always_comb begin
    hs_act    = (HS == SYNC_POL);
    vs_act    = (VS == SYNC_POL);
    hle       = hs_act && (hs_prev != SYNC_POL);
    vle       = vs_act && (vs_prev != SYNC_POL);
    frame_hle = hle && (vs_pend || vle);
    line_ok   = (({1'b0, h_cnt} + 11'd1) == H_TOTAL) && (hs_width == HS_LEN);
    frame_ok  = (({1'b0, v_cnt} + 11'd1) == V_TOTAL);
    chk_fail  = (hle && !line_ok) || (frame_hle && !frame_ok);
    visible   = ({1'b0, h_cnt} >= H_START) && ({1'b0, h_cnt} < H_END) &&
                ({1'b0, v_cnt} >= V_START) && ({1'b0, v_cnt} < V_END);
    vis_de    = visible && (state == ST_LOCKED) && !chk_fail;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_SEARCH;
      hs_prev     <= ~SYNC_POL;
      vs_prev     <= ~SYNC_POL;
      vs_pend     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_width    <= '0;
      good_cnt    <= '0;
      x_out       <= '0;
      y_out       <= '0;
      de          <= 1'b0;
      pixel_out   <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      if (pix_en) begin
        hs_prev <= HS;
        vs_prev <= VS;

        if (hle) begin
          h_cnt    <= '0;
          hs_width <= 10'd1;
        end else begin
          if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 10'd1;
          if (hs_act && (hs_width != CNT_MAX)) hs_width <= hs_width + 10'd1;
        end

        // A VS edge is only acted upon at the next HS leading edge (possibly this one).
        if (frame_hle) begin
          v_cnt   <= '0;
          vs_pend <= 1'b0;
        end else begin
          if (vle) vs_pend <= 1'b1;
          if (hle && (v_cnt != CNT_MAX)) v_cnt <= v_cnt + 10'd1;
        end

        de <= vis_de;
        if (visible) begin
          x_out     <= h_cnt - H_START[9:0];
          y_out     <= v_cnt - V_START[9:0];
          pixel_out <= RGB;
        end

        case (state)
          ST_SEARCH: begin
            if (frame_hle) begin
              state    <= ST_VERIFY;
              good_cnt <= '0;
            end
          end
          ST_VERIFY: begin
            if (chk_fail) begin
              state <= ST_SEARCH;
            end else if (frame_hle) begin
              good_cnt <= good_cnt + 1'b1;
              if (good_cnt == GOOD_LAST) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (chk_fail) begin
              timing_err <= 1'b1;
              locked     <= 1'b0;
              state      <= ST_SEARCH;
            end else if (frame_hle) begin
              frame_start <= 1'b1;
            end
          end
          default: begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VGA_RX_FRAME_SUM_EN
  logic [15:0] sum_acc;

  // The frame-HLE sample itself is never visible, so it is never part of the sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (pix_en) begin
      if ((state == ST_LOCKED) && chk_fail) begin
        sum_acc <= '0;
      end else if ((state == ST_LOCKED) && frame_hle) begin
        frame_sum <= sum_acc;
        sum_acc   <= '0;
      end else if (vis_de) begin
        sum_acc <= sum_acc + {8'd0, RGB};
      end
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule
